// File: rtl/share_detector_if.sv
// Digest handshake, target load and result bus between the SHA-256 core side
// (master) and the share detector (slave).
interface share_detector_if #(
  parameter int NONCE_W = 32,
  parameter int CNT_W   = 32,
  parameter int SHARE_W = 16
);
  logic               hash_valid;
  logic               hash_ready;
  logic [31:0]        h1, h2, h3, h4, h5, h6, h7, h8;
  logic [NONCE_W-1:0] nonce_in;
  logic               target_load;
  logic [255:0]       target_in;
  logic               found;
  logic [NONCE_W-1:0] found_nonce;
  logic [31:0]        found_h1;
  logic [CNT_W-1:0]   hash_count;
  logic [SHARE_W-1:0] share_count;

  modport master (
    output hash_valid, h1, h2, h3, h4, h5, h6, h7, h8, nonce_in,
           target_load, target_in,
    input  hash_ready, found, found_nonce, found_h1, hash_count, share_count
  );

  modport slave (
    input  hash_valid, h1, h2, h3, h4, h5, h6, h7, h8, nonce_in,
           target_load, target_in,
    output hash_ready, found, found_nonce, found_h1, hash_count, share_count
  );
endinterface

// File: rtl/share_detector.sv
// Compares each accepted 256-bit digest against a snapshot of the target, one
// word per cycle from the most significant end, and reports shares (digest <= target).
module share_detector #(
  parameter int NONCE_W = 32,
  parameter int CNT_W   = 32,
  parameter int SHARE_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  share_detector_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_e;

  localparam logic [255:0]       TargetReset = {32'h0000_0000, 32'hFFFF_0000, 192'h0};
  localparam logic [SHARE_W-1:0] ShareMax    = '1;

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0][31:0]   digest_q, digest_d;
  logic [7:0][31:0]   snap_q, snap_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [255:0]       target_q, target_d;
  logic               found_q, found_d;
  logic [NONCE_W-1:0] foundNonce_q, foundNonce_d;
  logic [31:0]        foundH1_q, foundH1_d;
  logic [CNT_W-1:0]   hashCount_q, hashCount_d;
  logic [SHARE_W-1:0] shareCount_q, shareCount_d;

  logic [31:0] curDigest;
  logic [31:0] curTarget;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      digest_q     <= '0;
      snap_q       <= '0;
      nonce_q      <= '0;
      target_q     <= TargetReset;
      found_q      <= 1'b0;
      foundNonce_q <= '0;
      foundH1_q    <= '0;
      hashCount_q  <= '0;
      shareCount_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      digest_q     <= digest_d;
      snap_q       <= snap_d;
      nonce_q      <= nonce_d;
      target_q     <= target_d;
      found_q      <= found_d;
      foundNonce_q <= foundNonce_d;
      foundH1_q    <= foundH1_d;
      hashCount_q  <= hashCount_d;
      shareCount_q <= shareCount_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    digest_d     = digest_q;
    snap_d       = snap_q;
    nonce_d      = nonce_q;
    target_d     = bus.target_load ? bus.target_in : target_q;
    found_d      = 1'b0;
    foundNonce_d = foundNonce_q;
    foundH1_d    = foundH1_q;
    hashCount_d  = hashCount_q;
    shareCount_d = shareCount_q;
    curDigest    = digest_q[idx_q];
    curTarget    = snap_q[idx_q];

    unique case (state_q)
      IDLE: begin
        if (bus.hash_valid) begin
          digest_d = {bus.h8, bus.h7, bus.h6, bus.h5, bus.h4, bus.h3, bus.h2, bus.h1};
          nonce_d  = bus.nonce_in;
          // Snapshot the pre-load target so a load on this edge only affects later digests.
          for (int i = 0; i < 8; i++) begin
            snap_d[i] = target_q[255-32*i -: 32];
          end
          idx_d   = '0;
          state_d = CMP;
        end
      end
      CMP: begin
        if ((curDigest != curTarget) || (idx_q == 3'd7)) begin
          state_d     = DONE;
          hashCount_d = hashCount_q + CNT_W'(1);
          if (curDigest <= curTarget) begin
            found_d      = 1'b1;
            foundNonce_d = nonce_q;
            foundH1_d    = digest_q[0];
            if (shareCount_q != ShareMax) begin
              shareCount_d = shareCount_q + SHARE_W'(1);
            end
          end
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.hash_ready  = (state_q == IDLE);
  assign bus.found       = found_q;
  assign bus.found_nonce = foundNonce_q;
  assign bus.found_h1    = foundH1_q;
  assign bus.hash_count  = hashCount_q;
  assign bus.share_count = shareCount_q;

endmodule
